// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Programmable VGA raster timing generator (640x480@60 by default).
// The beam advances one pixel per clk cycle in which pix_en is high. All
// outputs are registered and always describe the counter values currently
// presented, so downstream colour logic needs no latency compensation.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   pix_en      pixel-step enable
//   hsync       horizontal sync (polarity set by SYNC_ACTIVE_LOW)
//   vsync       vertical sync   (polarity set by SYNC_ACTIVE_LOW)
//   display_en  beam inside the visible area
//   counter_x   current pixel column
//   counter_y   current line
//   line_start  one-clk pulse on entry to column 0
//   frame_start one-clk pulse on entry to (0,0)
//   frame_count frames started, modulo 256
module vga_timing_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       display_en,
    output logic [9:0] counter_x,
    output logic [9:0] counter_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits wide so a sync window ending exactly at
    // 1024 (zero back porch, maximum total) still compares correctly.
    localparam logic [10:0] X_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] X_HS0  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] X_HS1  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] Y_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] Y_VS0  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] Y_VS1  = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW == 0) ? 1'b1 : 1'b0;
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic        x_wrap;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic        hsync_next;
    logic        vsync_next;
    logic        display_next;
    logic        line_next;
    logic        frame_next;

    // Outputs are decoded from the *next* counter values so that, once
    // registered, they line up with the counters on the same edge.
    always_comb begin
        x_wrap = (counter_x == X_LAST);
        x_next = x_wrap ? '0 : counter_x + 10'd1;
        y_next = counter_y;
        if (x_wrap) begin
            y_next = (counter_y == Y_LAST) ? '0 : counter_y + 10'd1;
        end

        x_ext = {1'b0, x_next};
        y_ext = {1'b0, y_next};

        display_next = (x_ext < X_ACT) && (y_ext < Y_ACT);
        hsync_next   = ((x_ext >= X_HS0) && (x_ext < X_HS1)) ? SYNC_ON : SYNC_OFF;
        vsync_next   = ((y_ext >= Y_VS0) && (y_ext < Y_VS1)) ? SYNC_ON : SYNC_OFF;
        line_next    = (x_next == '0);
        frame_next   = (x_next == '0) && (y_next == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_x   <= X_LAST;
            counter_y   <= Y_LAST;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            display_en  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '1;
        end else if (pix_en) begin
            counter_x   <= x_next;
            counter_y   <= y_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            display_en  <= display_next;
            line_start  <= line_next;
            frame_start <= frame_next;
            if (frame_next) begin
                frame_count <= frame_count + 8'd1;
            end
        end else begin
            // Strobes are single-clk pulses; level outputs hold.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Drives three instances (default 640x480 active-low timing, and a tiny
// raster in both sync polarities so frame wrap, vsync and frame_count
// rollover are reached quickly) from one random pix_en/reset stream.
// Expected outputs come from a model that only counts pixel steps since
// reset and derives position, regions and strobes arithmetically.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
    logic       h_hs, h_vs, h_de, h_ls, h_fs;
    logic [9:0] h_x, h_y;
    logic [7:0] h_fc;
    logic       l_hs, l_vs, l_de, l_ls, l_fs;
    logic [9:0] l_x, l_y;
    logic [7:0] l_fc;

    int n_checks = 0;
    int n_fail   = 0;
    int steps    = 0;
    bit last     = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(d_hs), .vsync(d_vs), .display_en(d_de),
        .counter_x(d_x), .counter_y(d_y),
        .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(h_hs), .vsync(h_vs), .display_en(h_de),
        .counter_x(h_x), .counter_y(h_y),
        .line_start(h_ls), .frame_start(h_fs), .frame_count(h_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hsync(l_hs), .vsync(l_vs), .display_en(l_de),
        .counter_x(l_x), .counter_y(l_y),
        .line_start(l_ls), .frame_start(l_fs), .frame_count(l_fc)
    );

    // Reference: after n steps the beam sits at raster index (n-1) mod
    // frame size; the reset position is the last pixel of the frame.
    function automatic obs_t model(int n, bit stepped,
                                   int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb,
                                   bit low);
        obs_t e;
        int ht, vt, ft, p, x, y;
        bit hs_on, vs_on;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        ft = ht * vt;
        p  = (n + ft - 1) % ft;
        x  = p % ht;
        y  = p / ht;
        hs_on = (x >= ha + hf) && (x < ha + hf + hsw);
        vs_on = (y >= va + vf) && (y < va + vf + vsw);
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.de = (x < ha) && (y < va);
        e.hs = hs_on ^ low;
        e.vs = vs_on ^ low;
        e.ls = stepped && (x == 0);
        e.fs = stepped && (p == 0);
        e.fc = 8'(((n + ft - 1) / ft + 255) % 256);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t steps=%0d)", tag, got, exp, $time, steps);
        end
    endtask

    task automatic check_inst(input string pfx, input obs_t got, input obs_t exp);
        check({pfx, ".x"},  32'(got.x),  32'(exp.x));
        check({pfx, ".y"},  32'(got.y),  32'(exp.y));
        check({pfx, ".de"}, 32'(got.de), 32'(exp.de));
        check({pfx, ".hs"}, 32'(got.hs), 32'(exp.hs));
        check({pfx, ".vs"}, 32'(got.vs), 32'(exp.vs));
        check({pfx, ".ls"}, 32'(got.ls), 32'(exp.ls));
        check({pfx, ".fs"}, 32'(got.fs), 32'(exp.fs));
        check({pfx, ".fc"}, 32'(got.fc), 32'(exp.fc));
    endtask

    task automatic compare_all();
        obs_t gd, gh, gl;
        gd = '{hs: d_hs, vs: d_vs, de: d_de, x: d_x, y: d_y, ls: d_ls, fs: d_fs, fc: d_fc};
        gh = '{hs: h_hs, vs: h_vs, de: h_de, x: h_x, y: h_y, ls: h_ls, fs: h_fs, fc: h_fc};
        gl = '{hs: l_hs, vs: l_vs, de: l_de, x: l_x, y: l_y, ls: l_ls, fs: l_fs, fc: l_fc};
        check_inst("def", gd, model(steps, last, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
        check_inst("shi", gh, model(steps, last, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0));
        check_inst("slo", gl, model(steps, last, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1));
    endtask

    initial begin
        int rhold;
        int mode;
        int gap;
        reset  = 1'b1;
        pix_en = 1'b0;
        rhold  = 3;
        mode   = 2;
        gap    = 0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            @(negedge clk);
            // Account for what the last rising edge did.
            if (reset) begin
                steps = 0;
                last  = 1'b0;
            end else begin
                last  = pix_en;
                steps = steps + int'(pix_en);
            end
            compare_all();

            if (rhold > 0) begin
                rhold--;
                if (rhold == 0) reset = 1'b0;
            end else if ($urandom_range(0, 4999) == 0) begin
                // Mid-frame reset must take effect without a clock edge.
                reset = 1'b1;
                rhold = $urandom_range(1, 3);
                #1;
                steps = 0;
                last  = 1'b0;
                compare_all();
            end

            if (cyc % 64 == 0) mode = (cyc < 2000) ? 2 : int'($urandom_range(0, 3));
            case (mode)
                0: pix_en = ($urandom_range(0, 3) != 0);
                1: pix_en = ~pix_en;
                2: pix_en = 1'b1;
                default: begin
                    if (gap == 0 && $urandom_range(0, 15) == 0) gap = $urandom_range(1, 100);
                    pix_en = (gap == 0);
                    if (gap > 0) gap--;
                end
            endcase
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
